countdown_timer: RTL

- Downstream consumer of the rate divider's enable pulse: counts down a BCD MM:SS value, one second per TICK_DIV tick pulses.
- Drives four BCD digits to the seven-segment decoders.
- Raises a one-cycle done pulse at 00:00 for game/control logic.
- Control is by start/pause/load strobes from debounced keys.

---
 rtl/countdown_timer_pkg.sv | 38 +++
 rtl/countdown_timer_digit.sv | 27 ++
 rtl/countdown_timer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the BCD MM:SS countdown timer.
package countdown_timer_pkg;

    // Controller states; 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Largest legal value of the seconds-tens digit and of every other digit
    localparam logic [3:0] SEC_T_MAX = 4'd5;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // Bit offsets of each digit in the 16-bit time vector {min_t, min_o, sec_t, sec_o}
    localparam int MIN_T_LSB = 12;
    localparam int MIN_O_LSB = 8;
    localparam int SEC_T_LSB = 4;
    localparam int SEC_O_LSB = 0;

    // Limit one digit to its maximum legal value
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] maxv);
        return (d > maxv) ? maxv : d;
    endfunction

    // Force a raw 16-bit load value into a legal MM:SS BCD time
    function automatic logic [15:0] clamp_time(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        r[MIN_T_LSB +: 4] = clamp_digit(v[MIN_T_LSB +: 4], DIGIT_MAX);
        r[MIN_O_LSB +: 4] = clamp_digit(v[MIN_O_LSB +: 4], DIGIT_MAX);
        r[SEC_T_LSB +: 4] = clamp_digit(v[SEC_T_LSB +: 4], SEC_T_MAX);
        r[SEC_O_LSB +: 4] = clamp_digit(v[SEC_O_LSB +: 4], DIGIT_MAX);
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD digit of the borrow chain: combinational decrement with wrap to MAX.
module bcd_down_digit
    import countdown_timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic [3:0] digit_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    // Decrement only when borrowed from; a zero digit wraps to MAX and passes the borrow on
    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (digit_i == 4'd0) begin
                digit_o  = MAX;
                borrow_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer: prescaled tick input, start/pause/load control,
// one-cycle done pulse on reaching 00:00.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int PRE_W    = 10
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        tick,
    input  logic        start,
    input  logic        pause,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [3:0]  min_t,
    output logic [3:0]  min_o,
    output logic [3:0]  sec_t,
    output logic [3:0]  sec_o,
    output logic        running,
    output logic        done
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [15:0]      time_q, time_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic [15:0]      dec_time;
    logic             borrow_sec_o, borrow_sec_t, borrow_min_o;
    // Borrow out of the top digit with a borrow forced in at the bottom means every digit is zero
    logic             time_zero;

    // Borrow chain: seconds ones always borrows, so dec_time is time_q minus one second
    bcd_down_digit #(.MAX(DIGIT_MAX)) u_sec_o (
        .digit_i  (time_q[SEC_O_LSB +: 4]),
        .borrow_i (1'b1),
        .digit_o  (dec_time[SEC_O_LSB +: 4]),
        .borrow_o (borrow_sec_o)
    );

    bcd_down_digit #(.MAX(SEC_T_MAX)) u_sec_t (
        .digit_i  (time_q[SEC_T_LSB +: 4]),
        .borrow_i (borrow_sec_o),
        .digit_o  (dec_time[SEC_T_LSB +: 4]),
        .borrow_o (borrow_sec_t)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_o (
        .digit_i  (time_q[MIN_O_LSB +: 4]),
        .borrow_i (borrow_sec_t),
        .digit_o  (dec_time[MIN_O_LSB +: 4]),
        .borrow_o (borrow_min_o)
    );

    bcd_down_digit #(.MAX(DIGIT_MAX)) u_min_t (
        .digit_i  (time_q[MIN_T_LSB +: 4]),
        .borrow_i (borrow_min_o),
        .digit_o  (dec_time[MIN_T_LSB +: 4]),
        .borrow_o (time_zero)
    );

    // Next-state, time, prescaler and output decode for the control FSM
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        pre_d   = pre_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    time_d = clamp_time(load_val);
                    pre_d  = '0;
                end else if (start && !time_zero) begin
                    state_d = ST_RUN;
                    pre_d   = '0;
                end
            end

            ST_RUN: begin
                // Pause beats both a coincident tick and start; load is ignored here
                if (pause) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        time_d = dec_time;
                        if (dec_time == 16'h0000) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end

            ST_PAUSE: begin
                // Resume keeps the partial prescaler count
                if (load) begin
                    time_d = clamp_time(load_val);
                    pre_d  = '0;
                end else if (start && !pause) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (load) begin
                    time_d  = clamp_time(load_val);
                    pre_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d == ST_RUN);
    end

    // State, time, prescaler and registered outputs; clear overrides every other input
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            time_q    <= '0;
            pre_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            pre_q     <= pre_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign min_t   = time_q[MIN_T_LSB +: 4];
    assign min_o   = time_q[MIN_O_LSB +: 4];
    assign sec_t   = time_q[SEC_T_LSB +: 4];
    assign sec_o   = time_q[SEC_O_LSB +: 4];
    assign running = running_q;
    assign done    = done_q;

endmodule
